// File: rtl/vga_capture_if.sv
// rtl/vga_capture_if.sv - video input and capture-FIFO write bundle for vga_capture
interface vga_capture_if;
   logic        pix_valid;
   logic        vga_hsync;
   logic        vga_vsync;
   logic        vid_active;
   logic [23:0] pix_data;
   logic        full;
   logic        wr_fifo;
   logic [23:0] wr_data;
   logic [9:0]  cap_x;
   logic [9:0]  cap_y;

   // video source / FIFO side
   modport master (
      output pix_valid, vga_hsync, vga_vsync, vid_active, pix_data, full,
      input  wr_fifo, wr_data, cap_x, cap_y
   );

   // capture block side
   modport slave (
      input  pix_valid, vga_hsync, vga_vsync, vid_active, pix_data, full,
      output wr_fifo, wr_data, cap_x, cap_y
   );
endinterface

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA sync lock and pixel capture; frame CRC when VGA_CAPTURE_CRC_EN is defined
module vga_capture #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 521
) (
   input  logic        clk,
   input  logic        rst,
   vga_capture_if.slave vid,
   input  logic        clr_err,
   output logic        locked,
   output logic        frame_start,
   output logic        ovf_err,
   output logic        fmt_err,
   output logic [15:0] frame_crc
);

   localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
   localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
   localparam logic [9:0] V_LEN = 10'(V_TOTAL);

   typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_t;

   state_t     state;
   logic       hs_hist;
   logic       vs_hist;
   logic [9:0] line_cnt;
   logic [9:0] x_cnt;
   logic [9:0] y_cnt;
   logic       line_vis;

   logic       hs_fall;
   logic       vs_fall;
   logic [9:0] line_next;
   logic       frame_ok;
   logic       pix_in;
   logic       pix_bad;
   logic       pix_take;
   logic       pix_write;

   // Sync edge detection and pixel qualification for the current sample.
   // An hsync coinciding with vsync is counted first, so frame_ok uses line_next.
   always_comb begin
      hs_fall   = vid.pix_valid & hs_hist & ~vid.vga_hsync;
      vs_fall   = vid.pix_valid & vs_hist & ~vid.vga_vsync;
      line_next = hs_fall ? line_cnt + 10'd1 : line_cnt;
      frame_ok  = (line_next == V_LEN);
      pix_in    = vid.pix_valid & vid.vid_active & (state == LOCKED);
      pix_bad   = pix_in & ((x_cnt == H_LIM) | (y_cnt >= V_LIM));
      pix_take  = pix_in & ~pix_bad;
      pix_write = pix_take & ~vid.full;
   end

   // Lock FSM, coordinate counters, FIFO write strobe and sticky errors.
   // Error sets are placed after the clear so that a coincident set wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= UNLOCKED;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         ovf_err     <= 1'b0;
         fmt_err     <= 1'b0;
         vid.wr_fifo <= 1'b0;
         vid.wr_data <= 24'd0;
         vid.cap_x   <= 10'd0;
         vid.cap_y   <= 10'd0;
         hs_hist     <= 1'b1;
         vs_hist     <= 1'b1;
         line_cnt    <= 10'd0;
         x_cnt       <= 10'd0;
         y_cnt       <= 10'd0;
         line_vis    <= 1'b0;
      end else begin
         vid.wr_fifo <= 1'b0;
         frame_start <= 1'b0;
         if (clr_err) begin
            ovf_err <= 1'b0;
            fmt_err <= 1'b0;
         end
         if (vid.pix_valid) begin
            hs_hist <= vid.vga_hsync;
            vs_hist <= vid.vga_vsync;
         end
         if (pix_write) begin
            vid.wr_fifo <= 1'b1;
            vid.wr_data <= vid.pix_data;
            vid.cap_x   <= x_cnt;
            vid.cap_y   <= y_cnt;
         end
         if (pix_take) begin
            x_cnt    <= x_cnt + 10'd1;
            line_vis <= 1'b1;
            if (vid.full)
               ovf_err <= 1'b1;
         end
         if (pix_bad) begin
            fmt_err <= 1'b1;
            state   <= UNLOCKED;
            locked  <= 1'b0;
         end
         if (hs_fall) begin
            line_cnt <= line_next;
            x_cnt    <= 10'd0;
            line_vis <= 1'b0;
            if (line_vis | pix_take)
               y_cnt <= y_cnt + 10'd1;
         end
         if (vs_fall) begin
            line_cnt <= 10'd0;
            x_cnt    <= 10'd0;
            y_cnt    <= 10'd0;
            line_vis <= 1'b0;
            case (state)
               UNLOCKED: state <= SYNCING;
               SYNCING: begin
                  if (frame_ok) begin
                     state       <= LOCKED;
                     locked      <= 1'b1;
                     frame_start <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (frame_ok && !pix_bad) begin
                     frame_start <= 1'b1;
                  end else begin
                     state   <= UNLOCKED;
                     locked  <= 1'b0;
                     fmt_err <= 1'b1;
                  end
               end
               default: begin
                  state  <= UNLOCKED;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef VGA_CAPTURE_CRC_EN
   logic [15:0] crc;
   logic [15:0] crc_pix;

   // CRC-16-CCITT over one 24-bit pixel, MSB first.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [23:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 23; i >= 0; i--)
         r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
      return r;
   endfunction

   // Running CRC including the pixel being written this sample.
   always_comb begin
      crc_pix = pix_write ? crc_step(crc, vid.pix_data) : crc;
   end

   // Accumulate written pixels; publish at a locked vsync and restart every frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc       <= 16'hFFFF;
         frame_crc <= 16'h0000;
      end else if (vs_fall) begin
         if (state == LOCKED)
            frame_crc <= crc_pix;
         crc <= 16'hFFFF;
      end else begin
         crc <= crc_pix;
      end
   end
`else
   assign frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - randomized self-checking bench for vga_capture with frame-level reference model
module tb_vga_capture;
   localparam int HA   = 16;
   localparam int VA   = 8;
   localparam int VT   = 13;
   localparam int LINE = 24;
   localparam int HS0  = 18;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr_err = 1'b0;
   logic        locked;
   logic        frame_start;
   logic        ovf_err;
   logic        fmt_err;
   logic [15:0] frame_crc;

   vga_capture_if bus();

   vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .V_TOTAL(VT)) dut (
      .clk         (clk),
      .rst         (rst),
      .vid         (bus),
      .clr_err     (clr_err),
      .locked      (locked),
      .frame_start (frame_start),
      .ovf_err     (ovf_err),
      .fmt_err     (fmt_err),
      .frame_crc   (frame_crc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] d;
      logic [9:0]  x;
      logic [9:0]  y;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         mon_e;
   int          n_checks = 0;
   int          n_pass = 0;
   int          fs_exp = 0;
   int          fs_seen = 0;
   logic        pv_q = 1'b0;

   // frame-level reference: 0 unlocked, 1 syncing, 2 locked
   int          m_st = 0;
   logic        m_ovf = 1'b0;
   logic        m_fmt = 1'b0;
   logic [15:0] m_crc = 16'hFFFF;
   logic [15:0] m_fcrc = 16'h0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // byte-at-a-time CRC-16-CCITT over the three pixel bytes, high byte first
   function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [23:0] d);
      logic [15:0] r;
      r = c;
      for (int b = 2; b >= 0; b--) begin
         r = r ^ {d[b*8 +: 8], 8'h00};
         for (int k = 0; k < 8; k++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      end
      return r;
   endfunction

   always @(posedge clk) pv_q <= bus.pix_valid;

   // write scoreboard and frame_start counter
   always @(negedge clk) begin
      if (!rst) begin
         if (frame_start) fs_seen++;
         if (bus.wr_fifo) begin
            check("wr_after_valid", 32'(pv_q), 32'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_wr", 32'(bus.cap_x), 32'hFFFF_FFFF);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_data", 32'(bus.wr_data), 32'(mon_e.d));
               check("cap_x", 32'(bus.cap_x), 32'(mon_e.x));
               check("cap_y", 32'(bus.cap_y), 32'(mon_e.y));
            end
         end
      end
   end

   task automatic put(input logic pv, input logic hs, input logic vs, input logic va,
                      input logic [23:0] d, input logic fl);
      bus.pix_valid  = pv;
      bus.vga_hsync  = hs;
      bus.vga_vsync  = vs;
      bus.vid_active = va;
      bus.pix_data   = d;
      bus.full       = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      put(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom), 1'($urandom));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      bus.pix_valid = 1'b0;
      bus.vga_hsync = 1'b1;
      bus.vga_vsync = 1'b1;
      bus.vid_active = 1'b0;
      bus.full = 1'b0;
      #1;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_frame_start", 32'(frame_start), 32'd0);
      check("rst_wr_fifo", 32'(bus.wr_fifo), 32'd0);
      check("rst_wr_data", 32'(bus.wr_data), 32'd0);
      check("rst_cap_x", 32'(bus.cap_x), 32'd0);
      check("rst_cap_y", 32'(bus.cap_y), 32'd0);
      check("rst_ovf", 32'(ovf_err), 32'd0);
      check("rst_fmt", 32'(fmt_err), 32'd0);
      check("rst_crc", 32'(frame_crc), 32'd0);
      check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      m_st = 0; m_ovf = 1'b0; m_fmt = 1'b0; m_crc = 16'hFFFF; m_fcrc = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      idle();
      clr_err = 1'b0;
      m_ovf = 1'b0;
      m_fmt = 1'b0;
      check("clr_ovf", 32'(ovf_err), 32'd0);
      check("clr_fmt", 32'(fmt_err), 32'd0);
   endtask

   // One frame of n lines; vsync falls with the last line's hsync.
   // mode 0: pix_valid always high, 1: alternating, 2: random gaps and random full.
   task automatic run_frame(input int n, input int vis_l, input int long_l, input int fb_start,
                            input int mode, input bit zero, input int abort_l);
      int          pidx;
      int          prev;
      bit          vis, hs, vs, fl, vsamp, exp_fs;
      logic [23:0] d;
      pidx = 0;
      exp_fs = 1'b0;
      for (int l = 0; l < n; l++) begin
         for (int c = 0; c < LINE; c++) begin
            if (l == abort_l && c == 10) return;
            vis   = (l < vis_l) && (c < HA || (l == long_l && c == HA));
            hs    = !(c >= HS0 && c < HS0 + 3);
            vs    = !(l == n - 1 && c >= HS0);
            vsamp = (l == n - 1 && c == HS0);
            d     = zero ? 24'h000000 : 24'($urandom);
            if (fb_start >= 0) fl = vis && pidx >= fb_start && pidx < fb_start + 10;
            else if (mode == 2) fl = ($urandom_range(0, 7) == 0);
            else fl = 1'b0;
            if (vis) pidx++;
            if (vis && m_st == 2) begin
               if (c >= HA || l >= VA) begin
                  m_fmt = 1'b1;
                  m_st  = 0;
               end else if (fl) begin
                  m_ovf = 1'b1;
               end else begin
                  exp_q.push_back('{d: d, x: 10'(c), y: 10'(l)});
                  m_crc = ref_crc(m_crc, d);
               end
            end
            if (vsamp) begin
               prev = m_st;
               if (prev == 2) m_fcrc = m_crc;
               m_crc  = 16'hFFFF;
               exp_fs = (prev != 0) && (n == VT);
               if (prev == 0) m_st = 1;
               else if (n == VT) m_st = 2;
               else if (prev == 2) begin m_st = 0; m_fmt = 1'b1; end
               if (exp_fs) fs_exp++;
            end
            put(1'b1, hs, vs, vis, d, fl);
            if (vsamp) begin
               check("vs_locked", 32'(locked), 32'(m_st == 2));
               check("vs_frame_start", 32'(frame_start), 32'(exp_fs));
               check("vs_fmt_err", 32'(fmt_err), 32'(m_fmt));
               check("vs_ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef VGA_CAPTURE_CRC_EN
               check("vs_frame_crc", 32'(frame_crc), 32'(m_fcrc));
`else
               check("vs_frame_crc", 32'(frame_crc), 32'd0);
`endif
            end
            if (mode == 1) idle();
            else if (mode == 2 && $urandom_range(0, 3) == 0)
               repeat ($urandom_range(1, 2)) idle();
         end
      end
   endtask

   initial begin
      bus.pix_valid = 1'b0;
      bus.vga_hsync = 1'b1;
      bus.vga_vsync = 1'b1;
      bus.vid_active = 1'b0;
      bus.pix_data = 24'd0;
      bus.full = 1'b0;
      do_reset();

      // acquire lock: one frame to enter syncing, one full frame in syncing
      repeat (4) run_frame(VT, VA, -1, -1, 0, 1'b0, -1);

      // short frame while locked, then resync
      run_frame(VT - 1, VA, -1, -1, 0, 1'b0, -1);
      run_frame(VT, VA, -1, -1, 0, 1'b0, -1);
      run_frame(VT, VA, -1, -1, 0, 1'b0, -1);
      pulse_clr();

      // full held for 10 visible pixels starting at line 2, column 3
      run_frame(VT, VA, -1, 2 * HA + 3, 0, 1'b0, -1);
      pulse_clr();

      // alternating pix_valid, then random gaps and random full
      repeat (2) run_frame(VT, VA, -1, -1, 1, 1'b0, -1);
      repeat (2) run_frame(VT, VA, -1, -1, 2, 1'b0, -1);
      pulse_clr();

      // over-long line, then relock
      run_frame(VT, VA, 3, -1, 0, 1'b0, -1);
      repeat (2) run_frame(VT, VA, -1, -1, 0, 1'b0, -1);
      pulse_clr();

      // extra visible line, then relock
      run_frame(VT, VA + 1, -1, -1, 0, 1'b0, -1);
      repeat (2) run_frame(VT, VA, -1, -1, 0, 1'b0, -1);
      pulse_clr();

      // reset in the middle of a locked line, relock, then an all-zero frame
      run_frame(VT, VA, -1, -1, 0, 1'b0, 2);
      do_reset();
      repeat (2) run_frame(VT, VA, -1, -1, 0, 1'b0, -1);
      run_frame(VT, VA, -1, -1, 0, 1'b1, -1);
      run_frame(VT, VA, -1, -1, 2, 1'b0, -1);

      repeat (4) idle();
      check("end_pending_writes", 32'(exp_q.size()), 32'd0);
      check("frame_start_count", 32'(fs_seen), 32'(fs_exp));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 The block SHALL have parameter V_TOTAL, default 521, total lines per frame (hsync assertions between vsync assertions).
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 The block SHALL have port pix_valid, input, 1, pixel-clock enable; all video inputs are sampled only when high.
REQ-007 The block SHALL have port vga_hsync, input, 1, horizontal sync, active-low.
REQ-008 The block SHALL have port vga_vsync, input, 1, vertical sync, active-low.
REQ-009 The block SHALL have port vid_active, input, 1, high = visible pixel.
REQ-010 The block SHALL have port pix_data, input, 24, RGB pixel.
REQ-011 The block SHALL have port full, input, 1, capture FIFO full.
REQ-012 The block SHALL have port clr_err, input, 1, clears sticky errors.
REQ-013 The block SHALL have port wr_fifo, output, 1, FIFO write strobe.
REQ-014 The block SHALL have port wr_data, output, 24, captured pixel.
REQ-015 The block SHALL have ports cap_x and cap_y, output, 10 each, coordinates of the pixel in wr_data.
REQ-016 The block SHALL have port locked, output, 1, high in LOCKED state.
REQ-017 The block SHALL have port frame_start, output, 1, one-clk pulse per locked frame.
REQ-018 The block SHALL have ports ovf_err and fmt_err, output, 1 each, sticky errors.
REQ-019 The block SHALL have port frame_crc, output, 16, last-frame CRC (see Configuration).

Function
REQ-020 Sync edges SHALL be detected between consecutive pix_valid samples; an "assertion" is a 1->0 transition.
REQ-021 FSM states SHALL be UNLOCKED, SYNCING, LOCKED; UNLOCKED->SYNCING on vsync assertion, with the line counter cleared.
REQ-022 In SYNCING, every hsync assertion SHALL increment the 10-bit line counter; on the next vsync assertion: count==V_TOTAL -> LOCKED, otherwise stay in SYNCING with the counter cleared.
REQ-023 In LOCKED, a vsync assertion with line count != V_TOTAL SHALL go to UNLOCKED and set fmt_err.
REQ-024 In LOCKED, a visible pixel with cap_x already at H_ACTIVE, or a visible line beyond V_ACTIVE, SHALL be dropped, set fmt_err and go to UNLOCKED.
REQ-025 cap_x SHALL advance by 1 per captured visible pixel and clear on hsync assertion.
REQ-026 cap_y SHALL clear on vsync assertion and advance by 1 on hsync assertion only if the ending line contained a visible pixel.
REQ-027 Pixels SHALL be captured only in LOCKED, when pix_valid=1 and vid_active=1.
REQ-028 A captured pixel SHALL produce wr_fifo=1 for exactly one clk in the cycle following the sample, with wr_data/cap_x/cap_y registered alongside it; latency is 1 clk.
REQ-029 A captured pixel with full=1 SHALL NOT be written; ovf_err SHALL set; coordinates still advance.
REQ-030 frame_start SHALL pulse one clk after a vsync assertion sampled while LOCKED (including the transition into LOCKED).
REQ-031 ovf_err and fmt_err SHALL hold until clr_err=1; if a set and clr_err coincide, set wins.
REQ-032 Simultaneous hsync and vsync assertion SHALL be processed as hsync first (line counted), then vsync.
REQ-033 wr_fifo SHALL be 0 outside LOCKED and whenever pix_valid was 0 in the sampling cycle.

Reset
REQ-034 rst SHALL force state UNLOCKED, all outputs 0, line counter 0, edge-detect history 1 (syncs deasserted), and the CRC register to 16'hFFFF, mid-frame included.
REQ-035 After rst deasserts, the block SHALL require one full correct frame in SYNCING before asserting locked.

Configuration
REQ-036 Macro VGA_CAPTURE_CRC_EN defined: a CRC-16-CCITT (poly 0x1021, init 0xFFFF) SHALL be computed over every written pix_data, MSB first; it SHALL be latched to frame_crc on each vsync assertion in LOCKED, then re-initialised.
REQ-037 Macro VGA_CAPTURE_CRC_EN undefined: frame_crc SHALL be constant 0 and no CRC logic SHALL be present.

Verification
REQ-038 Two correct 800x521 frames, pix_valid=1 -> locked rises at the 2nd vsync assertion, frame_start pulses, then 307200 writes per frame with last write at cap_x=639, cap_y=479.
REQ-039 Frame with 520 lines while LOCKED -> fmt_err=1, locked=0; next correct frame -> SYNCING; the one after -> locked=1.
REQ-040 full=1 held for 10 visible pixels -> no wr_fifo for those pixels, ovf_err=1, next write at cap_x advanced by 10; clr_err pulse -> ovf_err=0.
REQ-041 pix_valid toggled 1/0 each clk -> identical write sequence and coordinates as REQ-038, with wr_fifo never set in the cycle after a pix_valid=0 sample.
REQ-042 rst pulse mid-line at cap_x=300 -> all outputs 0 next cycle, locked reacquired only after a full SYNCING frame.
REQ-043 With VGA_CAPTURE_CRC_EN, a frame of all pix_data=24'h000000 -> frame_crc equals model value at next vsync; without the macro, frame_crc=0.
